// File: rtl/md_if.sv
// Issue/result bundle between the core pipeline and the multiply/divide unit.
// The core side drives the issue fields; the unit returns busy and the HI/LO registers.
interface md_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed from operands latched at issue and committed when the busy window ends.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    md_if.slave   bus
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MAX_L = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW    = $clog2(MAX_L + 1);

    logic [0:0]         state_r;
    logic               busy_r;
    logic [CW-1:0]      cnt_r;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic [2*WIDTH-1:0] a_ext_s;
    logic [2*WIDTH-1:0] b_ext_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   quo_mag_s;
    logic [WIDTH-1:0]   rem_mag_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [2*WIDTH-1:0] res_s;
    logic               wr_s;
    logic               is_move_s;

    // Sign-extending to the full product width makes a modular multiply give the signed product.
    assign a_ext_s = (op_r == OP_MULTU) ? {{WIDTH{1'b0}}, a_r} : {{WIDTH{a_r[WIDTH-1]}}, a_r};
    assign b_ext_s = (op_r == OP_MULTU) ? {{WIDTH{1'b0}}, b_r} : {{WIDTH{b_r[WIDTH-1]}}, b_r};
    assign prod_s  = a_ext_s * b_ext_s;

    // Signed divide works on magnitudes; most-negative / -1 falls out as lo=a, hi=0.
    assign a_neg_s   = (op_r == OP_DIV) & a_r[WIDTH-1];
    assign b_neg_s   = (op_r == OP_DIV) & b_r[WIDTH-1];
    assign a_mag_s   = a_neg_s ? -a_r : a_r;
    assign b_mag_s   = b_neg_s ? -b_r : b_r;
    assign quo_mag_s = (b_mag_s == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : a_mag_s / b_mag_s;
    assign rem_mag_s = (b_mag_s == {WIDTH{1'b0}}) ? {WIDTH{1'b0}} : a_mag_s % b_mag_s;
    assign quo_s     = (a_neg_s ^ b_neg_s) ? -quo_mag_s : quo_mag_s;
    assign rem_s     = a_neg_s ? -rem_mag_s : rem_mag_s;

    assign is_move_s = (bus.op == OP_MTHI) || (bus.op == OP_MTLO);

    // Select the {hi,lo} value to commit and whether a commit happens at all.
    always_comb begin
        res_s = acc_r;
        wr_s  = 1'b0;
        case (op_r)
            OP_MULT, OP_MULTU: begin
                res_s = prod_s;
                wr_s  = 1'b1;
            end
            OP_MADD: begin
                res_s = acc_r + prod_s;
                wr_s  = 1'b1;
            end
            OP_MSUB: begin
                res_s = acc_r - prod_s;
                wr_s  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_s = {rem_s, quo_s};
                wr_s  = (b_r != {WIDTH{1'b0}});
            end
            default: begin
                res_s = acc_r;
                wr_s  = 1'b0;
            end
        endcase
    end

    // Issue, busy countdown and HI/LO commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            op_r    <= 3'd0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && is_move_s) begin
                        if (bus.op == OP_MTHI) begin
                            hi_r <= bus.a;
                        end else begin
                            lo_r <= bus.a;
                        end
                    end else if (bus.start) begin
                        op_r    <= bus.op;
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        acc_r   <= {hi_r, lo_r};
                        cnt_r   <= ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) ?
                                   CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        if (wr_s) begin
                            hi_r <= res_s[2*WIDTH-1:WIDTH];
                            lo_r <= res_s[WIDTH-1:0];
                        end
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_md_unit.sv
// Randomised bench for md_unit against an arithmetic reference model of HI/LO.
module tb_md_unit;
    localparam int W  = 32;
    localparam int LM = 5;
    localparam int LD = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_if #(.WIDTH(W)) m ();

    md_unit #(.WIDTH(W), .MULT_CYCLES(LM), .DIV_CYCLES(LD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m.slave)
    );

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void model_apply(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      sx, sy, q, r;
        logic [63:0] prod, acc;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        prod = 64'(sx * sy);
        acc  = {exp_hi, exp_lo};
        case (o)
            3'd0: {exp_hi, exp_lo} = prod;
            3'd1: {exp_hi, exp_lo} = {32'd0, x} * {32'd0, y};
            3'd2: if (y != 32'd0) begin
                q = sx / sy;
                r = sx % sy;
                exp_lo = q[W-1:0];
                exp_hi = r[W-1:0];
            end
            3'd3: if (y != 32'd0) begin
                exp_lo = x / y;
                exp_hi = x % y;
            end
            3'd4: exp_hi = x;
            3'd5: exp_lo = x;
            3'd6: {exp_hi, exp_lo} = acc + prod;
            default: {exp_hi, exp_lo} = acc - prod;
        endcase
    endfunction

    task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        m.start = 1'b1; m.op = o; m.a = x; m.b = y;
        @(posedge clk); #1;
        m.start = 1'b0;
    endtask

    // Issues one op and checks the whole busy window; a stray start can be injected at window edge stray_i.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int stray_i, input logic [2:0] stray_op);
        logic [W-1:0] old_hi, old_lo;
        int L;
        old_hi = exp_hi;
        old_lo = exp_lo;
        drive(o, x, y);
        model_apply(o, x, y);
        if (o == 3'd4 || o == 3'd5) begin
            check_val("move_busy", m.busy, 64'd0);
            check_val("move_hi", m.hi, exp_hi);
            check_val("move_lo", m.lo, exp_lo);
        end else begin
            L = (o == 3'd2 || o == 3'd3) ? LD : LM;
            check_val("busy_rise", m.busy, 64'd1);
            for (int i = 1; i <= L; i++) begin
                if (i == stray_i) begin
                    m.start = 1'b1; m.op = stray_op; m.a = $urandom; m.b = $urandom;
                end
                @(posedge clk); #1;
                m.start = 1'b0;
                if (i < L) begin
                    check_val("busy_hold", m.busy, 64'd1);
                    check_val("hi_hold", m.hi, old_hi);
                    check_val("lo_hold", m.lo, old_lo);
                end
            end
            check_val("busy_fall", m.busy, 64'd0);
            check_val("res_hi", m.hi, exp_hi);
            check_val("res_lo", m.lo, exp_lo);
        end
    endtask

    initial begin
        logic [2:0]   o;
        logic [W-1:0] x, y;
        reset = 1'b1;
        m.start = 1'b1; m.op = 3'd4; m.a = 32'hDEAD_BEEF; m.b = 32'd1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", m.busy, 64'd0);
        check_val("rst_hi", m.hi, 64'd0);
        check_val("rst_lo", m.lo, 64'd0);
        @(negedge clk);
        reset = 1'b0; m.start = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 3'd0);
        check_val("mult_hi_k", m.hi, 64'hFFFF_FFFF);
        check_val("mult_lo_k", m.lo, 64'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 3'd0);
        check_val("multu_hi_k", m.hi, 64'h2);
        check_val("multu_lo_k", m.lo, 64'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 3'd0);
        check_val("div_lo_k", m.lo, 64'hFFFF_FFFD);
        check_val("div_hi_k", m.hi, 64'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd0, 0, 3'd0);
        check_val("div0_lo_k", m.lo, 64'hFFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0);
        check_val("ovf_lo_k", m.lo, 64'h8000_0000);
        check_val("ovf_hi_k", m.hi, 64'h0);
        run_op(3'd4, 32'd5, 32'd0, 0, 3'd0);
        run_op(3'd5, 32'd7, 32'd0, 0, 3'd0);
        run_op(3'd6, 32'd2, 32'd3, 0, 3'd0);
        check_val("madd_k", {m.hi, m.lo}, {32'd5, 32'd13});
        run_op(3'd4, 32'd5, 32'd0, 0, 3'd0);
        run_op(3'd5, 32'd7, 32'd0, 0, 3'd0);
        run_op(3'd7, 32'd2, 32'd3, 0, 3'd0);
        check_val("msub_k", {m.hi, m.lo}, {32'd5, 32'd1});
        run_op(3'd0, 32'd3, 32'd4, 2, 3'd5);
        check_val("mtlo_mid_k", m.lo, 64'd12);
        run_op(3'd0, 32'd6, 32'd7, LM, 3'd5);
        run_op(3'd1, 32'd9, 32'd9, 0, 3'd0);
        check_val("b2b_k", m.lo, 64'd81);

        drive(3'd2, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("rstmid_busy", m.busy, 64'd0);
        check_val("rstmid_hi", m.hi, 64'd0);
        check_val("rstmid_lo", m.lo, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        repeat (LD) @(posedge clk);
        #1;
        check_val("rstmid_after", {m.hi, m.lo}, 64'd0);

        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 4) == 0) y = 32'd0;
            if ($urandom_range(0, 4) == 0) y = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 9) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            run_op(o, x, y, $urandom_range(0, LD), 3'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
